// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and FSM state type for the picoMIPS fetch stage
package fetch_pkg;
  localparam int PSIZE = 4;
  localparam int ISIZE = 17;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
endpackage

// File: rtl/pc_fetch_pc.sv
// pc: program counter register and next-PC mux; relative branch built only with PC_RELBRANCH_EN
module pc
  import fetch_pkg::*;
#(
  parameter int Psize = PSIZE
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             adv,
  input  logic             valid,
  input  logic             abs,
  input  logic             rel,
  input  logic [Psize-1:0] branchaddr,
  input  logic [Psize-1:0] base,
  output logic [Psize-1:0] address,
  output logic             taken
);
  logic             rel_en;
  logic [Psize-1:0] rel_target;
  logic [Psize-1:0] next;
`ifdef PC_RELBRANCH_EN
  assign rel_en = rel;
  // offset and PC share a width, so sign extension is implicit in the modular add
  assign rel_target = base + branchaddr;
`else
  logic [Psize:0] unused_rel;
  assign unused_rel = {rel, base};
  assign rel_en = 1'b0;
  assign rel_target = '0;
`endif
  assign taken = valid & (abs | rel_en);
  assign next = valid & abs ? branchaddr : valid & rel_en ? rel_target : address + 1'b1;
  always_ff @(posedge clk)
    if (!nReset) address <= '0;
    else if (adv) address <= next;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC plus instruction register with branch bubble, stall and halt; optional PC_RELBRANCH_EN
module pc_fetch
  import fetch_pkg::*;
#(
  parameter int Psize = PSIZE,
  parameter int Isize = ISIZE
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             en,
  input  logic             PCabsbranch,
  input  logic             PCrelbranch,
  input  logic [Psize-1:0] Branchaddr,
  input  logic             halt_req,
  output logic [Psize-1:0] address,
  input  logic [Isize-1:0] I,
  output logic [Isize-1:0] IR,
  output logic [Psize-1:0] IR_pc,
  output logic             IR_valid,
  output logic             halted
);
  state_t state, state_n;
  logic   live, stop, adv, taken;
  assign live = en && state != HALT;
  assign stop = live && halt_req && IR_valid;
  assign adv = live && !stop;
  pc #(.Psize(Psize)) u_pc (
    .clk       (clk),
    .nReset    (nReset),
    .adv       (adv),
    .valid     (IR_valid),
    .abs       (PCabsbranch),
    .rel       (PCrelbranch),
    .branchaddr(Branchaddr),
    .base      (IR_pc),
    .address   (address),
    .taken     (taken)
  );
  always_ff @(posedge clk)
    if (!nReset) state <= BOOT;
    else state <= state_n;
  always_comb state_n = stop ? HALT : adv ? RUN : state;
  always_comb halted = state == HALT;
  always_ff @(posedge clk)
    if (!nReset) begin
      IR       <= '0;
      IR_pc    <= '0;
      IR_valid <= 1'b0;
    end else if (adv) begin
      IR       <= I;
      IR_pc    <= address;
      IR_valid <= !taken;
    end else if (stop) IR_valid <= 1'b0;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed test-plan scenarios plus randomized run against a behavioural fetch model
module tb_pc_fetch;
  logic        clk = 0;
  logic        nReset = 0, en = 0, abs = 0, rel = 0, halt_req = 0;
  logic [3:0]  ba = 0;
  logic [3:0]  address, IR_pc;
  logic [16:0] I, IR;
  logic        IR_valid, halted;
  int tests = 0, fails = 0;
  int m_addr = 0, m_ir = 0, m_pc = 0;
  bit m_valid = 0, m_halt = 0;

  pc_fetch #(.Psize(4), .Isize(17)) dut (
    .clk(clk), .nReset(nReset), .en(en), .PCabsbranch(abs), .PCrelbranch(rel),
    .Branchaddr(ba), .halt_req(halt_req), .address(address), .I(I), .IR(IR),
    .IR_pc(IR_pc), .IR_valid(IR_valid), .halted(halted)
  );

  assign I = 17'(address) + 17'd100;
  always #5 clk = ~clk;

`ifdef PC_RELBRANCH_EN
  localparam bit REL = 1;
`else
  localparam bit REL = 0;
`endif

  task automatic model_step();
    int off, nxt;
    bit br_abs, br_rel;
    if (!nReset) begin
      m_addr = 0; m_ir = 0; m_pc = 0; m_valid = 0; m_halt = 0;
    end else if (!m_halt && en) begin
      if (halt_req && m_valid) begin
        m_halt = 1; m_valid = 0;
      end else begin
        br_abs = m_valid && abs;
        br_rel = m_valid && rel && REL;
        off = ba >= 8 ? int'(ba) - 16 : int'(ba);
        nxt = br_abs ? int'(ba) : br_rel ? (m_pc + off + 16) % 16 : (m_addr + 1) % 16;
        m_ir = m_addr + 100;
        m_pc = m_addr;
        m_addr = nxt;
        m_valid = !(br_abs || br_rel);
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_run(input int n);
    {abs, rel, halt_req, ba} = 0;
    nReset = 0; en = 1;
    cycle();
    nReset = 1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    nReset = 0; en = 1;
    cycle();
    tests++;
    if ({address, IR, IR_pc, IR_valid, halted} !== 27'd0) begin
      fails++;
      $display("FAIL reset: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want all 0", address, IR, IR_pc, IR_valid, halted);
    end
  endtask

  task automatic test_fetch_wrap();
    reset_run(0);
    for (int k = 1; k <= 16; k++) begin
      cycle();
      tests++;
      if ({address, IR, IR_pc, IR_valid} !== {4'(k), 17'(100 + k - 1), 4'(k - 1), 1'b1}) begin
        fails++;
        $display("FAIL fetch_wrap[%0d]: got addr=%0d IR=%0d IR_pc=%0d v=%b, want addr=%0d IR=%0d IR_pc=%0d v=1",
                 k, address, IR, IR_pc, IR_valid, k % 16, 100 + k - 1, k - 1);
      end
    end
  endtask

  task automatic test_absbranch();
    reset_run(4);
    abs = 1; ba = 9;
    cycle();
    abs = 0; ba = 0;
    tests++;
    if ({address, IR_valid} !== {4'd9, 1'b0}) begin
      fails++;
      $display("FAIL abs_branch: got addr=%0d v=%b, want addr=9 v=0", address, IR_valid);
    end
    cycle();
    tests++;
    if ({IR, IR_pc, IR_valid} !== {17'd109, 4'd9, 1'b1}) begin
      fails++;
      $display("FAIL abs_target: got IR=%0d IR_pc=%0d v=%b, want IR=109 IR_pc=9 v=1", IR, IR_pc, IR_valid);
    end
  endtask

  task automatic test_relbranch();
    reset_run(3);
    rel = 1; ba = 4'b1110;
    cycle();
    rel = 0; ba = 0;
    tests++;
    if ({address, IR_valid} !== (REL ? {4'd0, 1'b0} : {4'd4, 1'b1})) begin
      fails++;
      $display("FAIL rel_branch: got addr=%0d v=%b, want addr=%0d v=%b", address, IR_valid, REL ? 0 : 4, !REL);
    end
    cycle();
    tests++;
    if ({IR, IR_valid} !== {(REL ? 17'd100 : 17'd104), 1'b1}) begin
      fails++;
      $display("FAIL rel_target: got IR=%0d v=%b, want IR=%0d v=1", IR, IR_valid, REL ? 100 : 104);
    end
  endtask

  task automatic test_stall();
    reset_run(5);
    en = 0;
    for (int i = 0; i < 3; i++) begin
      {abs, rel, halt_req} = 3'($urandom);
      ba = 4'($urandom);
      cycle();
      tests++;
      if ({address, IR, IR_pc, IR_valid, halted} !== {4'd5, 17'd104, 4'd4, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL stall[%0d]: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want 5 104 4 1 0", i, address, IR, IR_pc, IR_valid, halted);
      end
    end
    {abs, rel, halt_req, ba} = 0;
    en = 1;
    cycle();
    tests++;
    if ({address, IR, IR_pc, IR_valid} !== {4'd6, 17'd105, 4'd5, 1'b1}) begin
      fails++;
      $display("FAIL stall_resume: got addr=%0d IR=%0d IR_pc=%0d v=%b, want 6 105 5 1", address, IR, IR_pc, IR_valid);
    end
  endtask

  task automatic test_halt();
    reset_run(8);
    halt_req = 1; abs = 1; ba = 3;
    cycle();
    tests++;
    if ({halted, IR_valid, address} !== {1'b1, 1'b0, 4'd8}) begin
      fails++;
      $display("FAIL halt_enter: got h=%b v=%b addr=%0d, want h=1 v=0 addr=8", halted, IR_valid, address);
    end
    for (int i = 0; i < 10; i++) begin
      {en, abs, rel, halt_req} = 4'($urandom);
      ba = 4'($urandom);
      cycle();
      tests++;
      if ({address, IR, IR_pc, IR_valid, halted} !== {4'd8, 17'd107, 4'd7, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL halt_hold[%0d]: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want 8 107 7 0 1", i, address, IR, IR_pc, IR_valid, halted);
      end
    end
    {abs, rel, halt_req, ba} = 0;
    nReset = 0; en = 1;
    cycle();
    tests++;
    if ({address, IR, IR_pc, IR_valid, halted} !== 27'd0) begin
      fails++;
      $display("FAIL halt_reset: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want all 0", address, IR, IR_pc, IR_valid, halted);
    end
    nReset = 1;
    cycle();
    tests++;
    if ({address, IR, IR_pc, IR_valid, halted} !== {4'd1, 17'd100, 4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL halt_restart: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want 1 100 0 1 0", address, IR, IR_pc, IR_valid, halted);
    end
  endtask

  task automatic test_random();
    reset_run(0);
    for (int i = 0; i < 3000; i++) begin
      nReset = $urandom_range(63) != 0;
      en = $urandom_range(3) != 0;
      abs = $urandom_range(5) == 0;
      rel = $urandom_range(4) == 0;
      halt_req = $urandom_range(40) == 0;
      ba = 4'($urandom);
      cycle();
      tests++;
      if ({address, IR, IR_pc, IR_valid, halted} !== {4'(m_addr), 17'(m_ir), 4'(m_pc), m_valid, m_halt}) begin
        fails++;
        $display("FAIL random[%0d]: got addr=%0d IR=%0d IR_pc=%0d v=%b h=%b, want addr=%0d IR=%0d IR_pc=%0d v=%b h=%b",
                 i, address, IR, IR_pc, IR_valid, halted, m_addr, m_ir, m_pc, m_valid, m_halt);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fetch_wrap();
    test_absbranch();
    test_relbranch();
    test_stall();
    test_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
